// File: rtl/controle_velocidade_pkg.sv
// ============================================================================
// Module      : controle_velocidade_pkg
// Description : Shared definitions for the speed controller: speed codes
//               driven to the display/motor stage and the FSM encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controle_velocidade_pkg;

    // Speed codes {chave1, chave2}; code 2'b11 is never produced.
    localparam logic [1:0] VEL_0   = 2'b00;
    localparam logic [1:0] VEL_1   = 2'b01;
    localparam logic [1:0] VEL_2   = 2'b10;
    localparam logic [1:0] VEL_MAX = 2'd2;

    typedef enum logic [1:0] {
        PARADO        = 2'd0,
        ACELERANDO    = 2'd1,
        CONSTANTE     = 2'd2,
        DESACELERANDO = 2'd3
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/controle_velocidade_debounce_botao.sv
// ============================================================================
// Module      : debounce_botao
// Description : Two-flop synchronizer, debounce counter and press-edge pulse
//               for one active-low push-button.
// Ports       : clock   - system clock
//               reset   - synchronous active-high reset
//               btn_n   - raw active-low button, asynchronous to clock
//               pulso   - one-cycle pulse on each accepted press
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic pulso
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          pressionado;
    logic          pressionado_d;
    logic [CW-1:0] contador;
    logic          amostra;

    // Synchronized sample expressed as "pressed" (active-high).
    assign amostra = ~sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            contador      <= '0;
            pressionado   <= 1'b0;
            pressionado_d <= 1'b0;
            pulso         <= 1'b0;
        end else begin
            sync1         <= btn_n;
            sync2         <= sync1;
            pressionado_d <= pressionado;
            pulso         <= pressionado & ~pressionado_d;
            // Any sample agreeing with the accepted level restarts the count,
            // so only an uninterrupted run of DEBOUNCE_CYCLES samples flips it.
            if (amostra == pressionado) begin
                contador <= '0;
            end else if (contador == CNT_MAX) begin
                pressionado <= amostra;
                contador    <= '0;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/controle_velocidade.sv
// ============================================================================
// Module      : controle_velocidade
// Description : Debounces up/down/stop buttons, keeps a target speed level and
//               ramps the current speed toward it one level per RAMP_CYCLES.
// Ports       : clock      - system clock
//               reset      - synchronous active-high reset
//               btn_up_n   - active-low "faster" button
//               btn_down_n - active-low "slower" button
//               btn_stop_n - active-low emergency stop
//               chave1     - speed code MSB
//               chave2     - speed code LSB
//               motor_en   - current speed is not zero
//               rampando   - current speed differs from target
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controle_velocidade
    import controle_velocidade_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RAMP_CYCLES     = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up_n,
    input  logic btn_down_n,
    input  logic btn_stop_n,
    output logic chave1,
    output logic chave2,
    output logic motor_en,
    output logic rampando
);

    localparam int            RW        = $clog2(RAMP_CYCLES + 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_CYCLES - 1);

    logic          pulso_up;
    logic          pulso_down;
    logic          pulso_stop;

    estado_t       estado;
    estado_t       estado_prox;
    logic [1:0]    alvo;
    logic [1:0]    alvo_prox;
    logic [1:0]    atual;
    logic [1:0]    atual_prox;
    logic [RW-1:0] rampa_cnt;
    logic [RW-1:0] rampa_prox;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_up_n),
        .pulso (pulso_up)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_down_n),
        .pulso (pulso_down)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_stop (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_stop_n),
        .pulso (pulso_stop)
    );

    // Target update and FSM transition are resolved together so the ramp
    // timer starts on the same edge the new target lands.
    always_comb begin
        alvo_prox   = alvo;
        atual_prox  = atual;
        estado_prox = estado;
        rampa_prox  = rampa_cnt;

        if (pulso_stop) begin
            alvo_prox   = VEL_0;
            atual_prox  = VEL_0;
            estado_prox = PARADO;
            rampa_prox  = '0;
        end else begin
            // Down outranks up, so a simultaneous press counts as down.
            if (pulso_down) begin
                if (alvo != VEL_0) alvo_prox = alvo - 2'd1;
            end else if (pulso_up) begin
                if (alvo != VEL_MAX) alvo_prox = alvo + 2'd1;
            end

            case (estado)
                PARADO: begin
                    if (alvo_prox != VEL_0) estado_prox = ACELERANDO;
                end
                CONSTANTE: begin
                    if (alvo_prox > atual)      estado_prox = ACELERANDO;
                    else if (alvo_prox < atual) estado_prox = DESACELERANDO;
                end
                ACELERANDO: begin
                    if (alvo_prox < atual) begin
                        estado_prox = DESACELERANDO;
                    end else if (alvo_prox == atual) begin
                        estado_prox = (atual == VEL_0) ? PARADO : CONSTANTE;
                    end else if (rampa_cnt == RAMP_LAST) begin
                        atual_prox = atual + 2'd1;
                        rampa_prox = '0;
                        if (atual + 2'd1 == alvo_prox) estado_prox = CONSTANTE;
                    end else begin
                        rampa_prox = rampa_cnt + 1'b1;
                    end
                end
                DESACELERANDO: begin
                    if (alvo_prox > atual) begin
                        estado_prox = ACELERANDO;
                    end else if (alvo_prox == atual) begin
                        estado_prox = (atual == VEL_0) ? PARADO : CONSTANTE;
                    end else if (rampa_cnt == RAMP_LAST) begin
                        atual_prox = atual - 2'd1;
                        rampa_prox = '0;
                        if (atual - 2'd1 == alvo_prox)
                            estado_prox = (alvo_prox == VEL_0) ? PARADO : CONSTANTE;
                    end else begin
                        rampa_prox = rampa_cnt + 1'b1;
                    end
                end
                default: estado_prox = PARADO;
            endcase

            if (estado_prox != estado) rampa_prox = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= PARADO;
            alvo      <= VEL_0;
            atual     <= VEL_0;
            rampa_cnt <= '0;
            motor_en  <= 1'b0;
            rampando  <= 1'b0;
        end else begin
            estado    <= estado_prox;
            alvo      <= alvo_prox;
            atual     <= atual_prox;
            rampa_cnt <= rampa_prox;
            // Derived from next-state values so they move on the same edge
            // as the speed code.
            motor_en  <= (atual_prox != VEL_0);
            rampando  <= (atual_prox != alvo_prox);
        end
    end

    assign chave1 = atual[1];
    assign chave2 = atual[0];

endmodule

`default_nettype wire

// File: tb/tb_controle_velocidade.sv
// ============================================================================
// Module      : tb_controle_velocidade
// Description : Self-checking bench for controle_velocidade. Expected outputs
//               are queued with the cycle they are due and compared on the
//               falling edge of that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controle_velocidade;

    localparam int DEB  = 4;
    localparam int RAMP = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_up_n = 1'b1;
    logic btn_down_n = 1'b1;
    logic btn_stop_n = 1'b1;
    logic chave1, chave2, motor_en, rampando;

    controle_velocidade #(.DEBOUNCE_CYCLES(DEB), .RAMP_CYCLES(RAMP)) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .btn_stop_n (btn_stop_n),
        .chave1     (chave1),
        .chave2     (chave2),
        .motor_en   (motor_en),
        .rampando   (rampando)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned     at;
        logic [1:0]      code;
        logic            me;
        logic            rp;
        logic [8*12-1:0] nm;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Scoreboard consumer: compare every entry due this cycle.
    always @(negedge clock) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            total++;
            if ({chave1, chave2} !== e.code || motor_en !== e.me || rampando !== e.rp) begin
                bad++;
                $display("FAIL %0s cyc=%0d got code=%b motor_en=%b rampando=%b want code=%b motor_en=%b rampando=%b",
                         e.nm, cyc, {chave1, chave2}, motor_en, rampando, e.code, e.me, e.rp);
            end
        end
    end

    task automatic push_exp(input int unsigned at, input logic [1:0] c, input logic me,
                            input logic rp, input logic [8*12-1:0] nm);
        exp_t e;
        int   i;
        e.at = at; e.code = c; e.me = me; e.rp = rp; e.nm = nm;
        i = 0;
        while (i < sbq.size() && sbq[i].at <= at) i++;
        sbq.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Mask bits: [2]=up, [1]=down, [0]=stop; 1 means pressed.
    task automatic set_btns(input logic [2:0] m);
        btn_up_n   = ~m[2];
        btn_down_n = ~m[1];
        btn_stop_n = ~m[0];
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sbq.size() > 0; i++) tick(1);
    endtask

    typedef struct {
        logic [2:0] btn;
        int         hold;
        int         settle;
        logic [1:0] c9;
        logic       me9;
        logic       rp9;
        logic [1:0] cf;
        logic       mef;
        logic       rpf;
    } vec_t;

    vec_t tab [9];

    initial begin
        #200us;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned k;

        // Rows start at level 2; each row presses, then checks just after the
        // target update (k+9) and once settled.
        tab[0] = '{3'b100,  6, 30, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0}; // up saturates
        tab[1] = '{3'b100,  6, 30, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        tab[2] = '{3'b100,  6, 30, 2'b10, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0};
        tab[3] = '{3'b010,  6, 30, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0}; // down 2->1
        tab[4] = '{3'b100,  6, 30, 2'b01, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0}; // up 1->2
        tab[5] = '{3'b010, 40, 50, 2'b10, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0}; // held: one step
        tab[6] = '{3'b110,  6, 30, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}; // up+down = down
        tab[7] = '{3'b100,  6, 30, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0}; // up 0->1
        tab[8] = '{3'b101,  6, 30, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}; // stop beats up

        set_btns(3'b000);
        reset = 1'b1;
        tick(3);
        k = cyc;
        for (int i = 0; i <= 50; i++) push_exp(k + i, 2'b00, 1'b0, 1'b0, "idle");
        reset = 1'b0;
        tick(50);
        wait_drain();

        // Two up presses from rest.
        k = cyc;
        push_exp(k + 7,  2'b00, 1'b0, 1'b0, "up1_pulse");
        push_exp(k + 8,  2'b00, 1'b0, 1'b1, "up1_tgt");
        push_exp(k + 15, 2'b00, 1'b0, 1'b1, "up1_hold");
        push_exp(k + 16, 2'b01, 1'b1, 1'b0, "up1_step");
        set_btns(3'b100); tick(10); set_btns(3'b000); tick(10);
        k = cyc;
        push_exp(k + 8,  2'b01, 1'b1, 1'b1, "up2_tgt");
        push_exp(k + 15, 2'b01, 1'b1, 1'b1, "up2_hold");
        push_exp(k + 16, 2'b10, 1'b1, 1'b0, "up2_step");
        set_btns(3'b100); tick(10); set_btns(3'b000); tick(10);
        wait_drain();
        tick(4);

        for (int r = 0; r < 9; r++) begin
            k = cyc;
            push_exp(k + 9, tab[r].c9, tab[r].me9, tab[r].rp9, "tab_early");
            push_exp(k + tab[r].settle, tab[r].cf, tab[r].mef, tab[r].rpf, "tab_final");
            set_btns(tab[r].btn);
            tick(tab[r].hold);
            set_btns(3'b000);
            tick(tab[r].settle - tab[r].hold);
            wait_drain();
            tick(2);
        end

        // Bounce shorter than the debounce window must never be accepted.
        k = cyc;
        for (int i = 1; i <= 40; i += 3) push_exp(k + i, 2'b00, 1'b0, 1'b0, "bounce");
        for (int i = 0; i < 5; i++) begin
            set_btns(3'b100); tick(2);
            set_btns(3'b000); tick(2);
        end
        tick(20);
        wait_drain();
        k = cyc;
        push_exp(k + 8,  2'b00, 1'b0, 1'b1, "clean_tgt");
        push_exp(k + 16, 2'b01, 1'b1, 1'b0, "clean_step");
        set_btns(3'b100); tick(6); set_btns(3'b000); tick(14);
        wait_drain();
        tick(4);

        // Stop while ramping 1 -> 2.
        k = cyc;
        push_exp(k + 9,  2'b01, 1'b1, 1'b1, "stop_ramp");
        push_exp(k + 12, 2'b01, 1'b1, 1'b1, "stop_pre");
        push_exp(k + 13, 2'b00, 1'b0, 1'b0, "stop_hit");
        push_exp(k + 25, 2'b00, 1'b0, 1'b0, "stop_after");
        btn_up_n = 1'b0; tick(5);
        btn_stop_n = 1'b0; tick(1);
        btn_up_n = 1'b1; tick(5);
        btn_stop_n = 1'b1; tick(15);
        wait_drain();
        tick(4);

        // Reset with the ramp counter at 5, then a full-latency restart.
        k = cyc;
        push_exp(k + 13, 2'b00, 1'b0, 1'b1, "rst_pre");
        push_exp(k + 14, 2'b00, 1'b0, 1'b0, "rst_hit");
        push_exp(k + 20, 2'b00, 1'b0, 1'b0, "rst_after");
        set_btns(3'b100); tick(6); set_btns(3'b000); tick(7);
        reset = 1'b1; tick(1);
        reset = 1'b0; tick(10);
        wait_drain();
        k = cyc;
        push_exp(k + 8,  2'b00, 1'b0, 1'b1, "rst_up_tgt");
        push_exp(k + 15, 2'b00, 1'b0, 1'b1, "rst_up_hold");
        push_exp(k + 16, 2'b01, 1'b1, 1'b0, "rst_up_step");
        set_btns(3'b100); tick(6); set_btns(3'b000); tick(14);
        wait_drain();

        if (sbq.size() > 0) begin
            $display("FAIL drain got %0d pending want 0 pending", sbq.size());
            bad += sbq.size();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/controle_velocidade.md
Name: controle_velocidade

Overview:
- Produces the 2-bit speed code (chave1, chave2) consumed by the current-speed 7-segment display block and the motor stage.
- Reads three active-low board push-buttons (up, down, stop), debounces them and keeps a target speed level.
- Ramps the current speed toward the target one level per RAMP_CYCLES, so the toy never jumps straight from stop to maximum speed.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a button must stay stable before it is accepted (10 ms at 50 MHz).
- RAMP_CYCLES, 25000000: cycles between successive one-level steps of the current speed.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_up_n  in  1  active-low "faster" button, asynchronous to clock.
- btn_down_n  in  1  active-low "slower" button, asynchronous to clock.
- btn_stop_n  in  1  active-low emergency stop, asynchronous to clock.
- chave1  out  1  speed code MSB to the display block.
- chave2  out  1  speed code LSB to the display block.
- motor_en  out  1  high while the current speed is not 0.
- rampando  out  1  high while the current speed differs from the target.

Behaviour:
- Speed levels and codes {chave1, chave2}:
  - level 0 = 00 (display shows 0)
  - level 1 = 01 (display shows 2)
  - level 2 = 10 (display shows 4)
  - Code 11 is never driven.
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: target = 0, current = 0, chave1 = 0, chave2 = 0, motor_en = 0, rampando = 0, all debouncers cleared to "released", FSM = PARADO, ramp counter = 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter that resets on any change. The output toggles only after DEBOUNCE_CYCLES consecutive equal samples.
  - Press-edge pulse: one cycle long, released-to-pressed transitions only.
  - Latency from a stable press to the pulse: DEBOUNCE_CYCLES + 3 cycles.
- Target update, on the cycle after a pulse:
  - up: target = min(target + 1, 2); saturates at 2, no wrap.
  - down: target = max(target - 1, 0); saturates at 0.
  - stop: target = 0 and current = 0 immediately; the ramp counter clears.
- Priority when pulses coincide in one cycle: stop > down > up. Up and down together count as down.
- FSM states: PARADO, ACELERANDO, CONSTANTE, DESACELERANDO.
  - PARADO: current = 0 = target. Goes to ACELERANDO when target > 0.
  - ACELERANDO: the ramp counter counts to RAMP_CYCLES-1, then current += 1 and the counter clears. Goes to CONSTANTE when current == target. Goes to DESACELERANDO if target drops below current.
  - DESACELERANDO: the same ramp counter, with current -= 1. Goes to PARADO when current == 0 == target. Goes to CONSTANTE when current == target > 0. Goes to ACELERANDO if target rises above current.
  - CONSTANTE: holds. Goes to ACELERANDO or DESACELERANDO when target changes.
- Ramp counter clears on every state change. First step latency after a target change is RAMP_CYCLES cycles.
- Stop from any state forces PARADO on the next cycle, overriding any ramp in progress.
- Output timing:
  - chave1/chave2 are registered and change on the same edge as current.
  - motor_en = (current != 0), registered.
  - rampando = (current != target), registered.
- Button held: only one pulse per press. A held button never auto-repeats.
- Bounce shorter than DEBOUNCE_CYCLES: no pulse.
- Reset asserted mid-ramp: next edge returns to reset values; no partial step is retained.

Decomposition:
- Shared package holds:
  - speed-code constants VEL_0 = 2'b00, VEL_1 = 2'b01, VEL_2 = 2'b10, VEL_MAX = 2;
  - FSM state encoding.
- Natural sub-module: debounce_botao, instantiated three times. It contains the synchronizer, the debounce counter and the edge pulse, with parameter DEBOUNCE_CYCLES, inputs clock, reset, btn_n and output pulso.
- Bench uses DEBOUNCE_CYCLES = 4 and RAMP_CYCLES = 8.

Test Plan:
- Reset, then idle for 50 cycles -> chave1 = 0, chave2 = 0, motor_en = 0, rampando = 0 throughout.
- Two up presses, each held for 10 cycles -> target = 2. First, rampando = 1 and code stays 00 for 8 cycles. Then code = 01 (motor_en = 1), and 8 cycles later code = 10. rampando then drops to 0 and the FSM is in CONSTANTE.
- At level 2, press up three more times -> code stays 10 with no wrap. Then one down press -> code 01 after 8 cycles.
- Bounce btn_up_n low/high every 2 cycles for 20 cycles, then release -> no pulse and target stays unchanged. A clean press held 4+ cycles -> exactly one pulse.
- At level 2, mid-ramp, assert stop -> next cycle code = 00, motor_en = 0, FSM in PARADO. Stop and up pressed in the same cycle -> stop wins and target = 0.
- Assert reset during ACELERANDO with the ramp counter at 5 -> next edge returns all outputs to 0. A subsequent up press waits the full 8 cycles before the first step.
